apb_to_ahbl: RTL and testbench

APB_TO_AHBL -- requirements
Module: apb_to_ahbl

---
 rtl/apb_to_ahbl.sv | 137 +++++++++++++
 tb/tb_apb_to_ahbl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_ahbl.sv
// APB responder to AHB-Lite initiator bridge: each APB access becomes one
// single-beat NONSEQ transfer and completes with a one-cycle pready pulse.
module apb_to_ahbl #(
    parameter int                 W_PADDR    = 16,
    parameter int                 W_HADDR    = 32,
    parameter int                 W_DATA     = 32,
    parameter logic [W_HADDR-1:0] HADDR_BASE = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    // APB responder
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    output logic               apbs_pready,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pslverr,
    // AHB-Lite initiator
    output logic [W_HADDR-1:0] ahblm_haddr,
    output logic               ahblm_hwrite,
    output logic [1:0]         ahblm_htrans,
    output logic [2:0]         ahblm_hsize,
    output logic [2:0]         ahblm_hburst,
    output logic [3:0]         ahblm_hprot,
    output logic               ahblm_hmastlock,
    output logic [W_DATA-1:0]  ahblm_hwdata,
    input  logic               ahblm_hready,
    input  logic               ahblm_hresp,
    input  logic [W_DATA-1:0]  ahblm_hrdata,
    // FSM state for observation
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_APH  = 2'd1,
        S_DPH  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [W_HADDR-1:0]  haddr_q,   haddr_d;
    logic                hwrite_q,  hwrite_d;
    logic [W_DATA-1:0]   hwdata_q,  hwdata_d;
    logic [W_DATA-1:0]   prdata_q,  prdata_d;
    logic                pslverr_q, pslverr_d;
    logic                err_q,     err_d;

    // Handshakes: an APB request is psel&&penable sampled in S_IDLE; it is
    // answered by pready=1 for one cycle in S_RESP. On AHB, hready=0 holds the
    // current address or data phase and all registered outputs stay unchanged.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (apbs_psel && apbs_penable) begin
                    state_d  = S_APH;
                    haddr_d  = {HADDR_BASE[W_HADDR-1:W_PADDR], apbs_paddr};
                    hwrite_d = apbs_pwrite;
                    if (apbs_pwrite) begin
                        hwdata_d = apbs_pwdata;
                    end
                end
            end
            S_APH: begin
                if (ahblm_hready) begin
                    state_d = S_DPH;
                end
            end
            S_DPH: begin
                if (ahblm_hresp) begin
                    err_d = 1'b1;
                end
                if (ahblm_hready) begin
                    // An errored read leaves the previous read data visible.
                    if (!hwrite_q && !(err_q || ahblm_hresp)) begin
                        prdata_d = ahblm_hrdata;
                    end
                    pslverr_d = err_q | ahblm_hresp;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                err_d     = 1'b0;
                pslverr_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            err_q     <= err_d;
        end
    end

    assign apbs_pready     = (state_q == S_RESP);
    assign apbs_pslverr    = (state_q == S_RESP) && pslverr_q;
    assign apbs_prdata     = prdata_q;

    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_htrans    = (state_q == S_APH) ? 2'b10 : 2'b00;
    assign ahblm_hsize     = 3'b010;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = hwdata_q;

    assign dbg_state       = state_q;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Bench for apb_to_ahbl: acts as APB requester and AHB-Lite responder and
// checks every cycle against a transaction-level timing/data model.
module tb_apb_to_ahbl;

    localparam int          W_PADDR    = 16;
    localparam int          W_HADDR    = 32;
    localparam int          W_DATA     = 32;
    localparam logic [31:0] HADDR_BASE = 32'hA000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               psel, penable, pwrite;
    logic [W_PADDR-1:0] paddr;
    logic [W_DATA-1:0]  pwdata;
    logic               pready;
    logic [W_DATA-1:0]  prdata;
    logic               pslverr;
    logic [W_HADDR-1:0] haddr;
    logic               hwrite;
    logic [1:0]         htrans;
    logic [2:0]         hsize, hburst;
    logic [3:0]         hprot;
    logic               hmastlock;
    logic [W_DATA-1:0]  hwdata;
    logic               hready, hresp;
    logic [W_DATA-1:0]  hrdata;
    logic [1:0]         dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W_DATA-1:0] prdata_model = '0;

    apb_to_ahbl #(
        .W_PADDR(W_PADDR), .W_HADDR(W_HADDR), .W_DATA(W_DATA), .HADDR_BASE(HADDR_BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_pready(pready),
        .apbs_prdata(prdata), .apbs_pslverr(pslverr),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = 1'b0;
            @(negedge clk);
            check("idle_htrans", htrans, 2'b00);
            check("idle_pready", pready, 1'b0);
        end
    endtask

    // One APB access with n_a address-phase and n_d data-phase wait states.
    // Expected completion is 3 + n_a + n_d cycles after the access cycle.
    task automatic do_xfer(input bit wr, input logic [W_PADDR-1:0] pa,
                           input logic [W_DATA-1:0] wd, input logic [W_DATA-1:0] rd,
                           input int n_a, input int n_d, input bit err,
                           input int n_setup, input bit setup_in_rst);
        logic [W_HADDR-1:0] exp_haddr;
        int k_dph, k_last, k_resp, nonseq, pulses;
        exp_haddr = ((HADDR_BASE >> W_PADDR) << W_PADDR) | W_HADDR'(pa);
        k_dph  = 2 + n_a;
        k_last = k_dph + n_d;
        k_resp = k_last + 1;
        nonseq = 0;
        pulses = 0;
        for (int s = 0; s < n_setup; s++) begin
            next_cycle();
            rst = setup_in_rst && (s == n_setup - 1);
            psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = pa; pwdata = wd;
            hready = 1'b1; hresp = 1'b0;
            @(negedge clk);
            if (!rst) begin
                check("setup_htrans", htrans, 2'b00);
                check("setup_pready", pready, 1'b0);
            end
        end
        next_cycle();
        rst = 1'b0; penable = 1'b1;
        @(negedge clk);
        check("access_htrans", htrans, 2'b00);
        check("access_pready", pready, 1'b0);
        for (int k = 1; k <= k_resp; k++) begin
            next_cycle();
            // APB inputs wander while busy; the bridge must not look at them.
            paddr  = W_PADDR'($urandom);
            pwdata = $urandom;
            pwrite = 1'($urandom_range(0, 1));
            hready = !((k <= n_a) || (k >= k_dph && k < k_last));
            hresp  = err && (k >= k_dph) && (k == k_last || k == k_last - 1);
            hrdata = (k == k_last) ? rd : $urandom;
            @(negedge clk);
            if (htrans == 2'b10 && hready) nonseq++;
            if (pready) pulses++;
            if (k <= 1 + n_a) begin
                check("aph_htrans", htrans, 2'b10);
                check("aph_haddr", haddr, exp_haddr);
                check("aph_hwrite", hwrite, wr);
            end else begin
                check("htrans_idle", htrans, 2'b00);
            end
            if (wr && k >= k_dph && k <= k_last) check("dph_hwdata", hwdata, wd);
            if (k == k_resp) begin
                if (!wr && !err) prdata_model = rd;
                check("resp_pready", pready, 1'b1);
                check("resp_pslverr", pslverr, err);
                check("resp_prdata", prdata, prdata_model);
            end else begin
                check("busy_pready", pready, 1'b0);
                check("busy_pslverr", pslverr, 1'b0);
            end
        end
        check("nonseq_count", nonseq, 1);
        check("pready_pulses", pulses, 1);
    endtask

    task automatic reset_mid_xfer();
        next_cycle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0123; hready = 1'b1; hresp = 1'b0;
        next_cycle();
        penable = 1'b1;
        next_cycle();
        hready = 1'b1;
        @(negedge clk);
        check("rmid_aph", htrans, 2'b10);
        next_cycle();
        hready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rmid_dph_htrans", htrans, 2'b00);
        next_cycle();
        rst = 1'b0; psel = 1'b0; penable = 1'b0; hready = 1'b1; hrdata = 32'hDEAD_BEEF;
        prdata_model = '0;
        @(negedge clk);
        check("rmid_htrans", htrans, 2'b00);
        check("rmid_pready", pready, 1'b0);
        check("rmid_pslverr", pslverr, 1'b0);
        check("rmid_prdata", prdata, prdata_model);
        check("rmid_haddr", haddr, 0);
        next_cycle();
        @(negedge clk);
        check("rmid_after_pready", pready, 1'b0);
    endtask

    initial begin
        bit wr, err;
        int n_d;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 0);
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 0);
        check("rst_hwrite", hwrite, 1'b0);
        check("rst_hwdata", hwdata, 0);
        check("tie_hsize", hsize, 3'b010);
        check("tie_hburst", hburst, 3'b000);
        check("tie_hprot", hprot, 4'b0011);
        check("tie_hmastlock", hmastlock, 1'b0);

        // Read right out of reset, zero wait states.
        do_xfer(1'b0, 16'h0040, '0, 32'hCAFEF00D, 0, 0, 1'b0, 1, 1'b1);
        idle_cycles(2);
        // Write with two address-phase stalls.
        do_xfer(1'b1, 16'h0010, 32'h12345678, '0, 2, 0, 1'b0, 1, 1'b0);
        idle_cycles(1);
        // Read with two-cycle error response.
        do_xfer(1'b0, 16'h0080, '0, 32'h5555_AAAA, 0, 1, 1'b1, 1, 1'b0);
        // Back-to-back writes, minimal gap.
        do_xfer(1'b1, 16'h0100, 32'h0BAD_F00D, '0, 0, 0, 1'b0, 1, 1'b0);
        do_xfer(1'b1, 16'h0104, 32'hFEED_FACE, '0, 0, 0, 1'b0, 1, 1'b0);
        // Long setup phase must not start a transfer.
        do_xfer(1'b0, 16'hFFFC, '0, 32'h0102_0304, 1, 2, 1'b0, 3, 1'b0);
        idle_cycles(1);
        reset_mid_xfer();
        do_xfer(1'b0, 16'h0040, '0, 32'h7777_1111, 0, 0, 1'b0, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 4) == 0);
            n_d = $urandom_range(0, 3);
            if (err && n_d == 0) n_d = 1;
            do_xfer(wr, W_PADDR'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), n_d, err, $urandom_range(1, 2), 1'b0);
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
